updown_counter: RTL and testbench

UPDOWN_COUNTER -- requirements
Module: updown_counter

---
 rtl/updown_counter.sv | 78 +++++++
 tb/tb_updown_counter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/updown_counter.sv
// Parameterised up/down counter with synchronous clear and load, wrap or
// saturate at the bounds, a one-cycle terminal-count pulse and a sticky overflow flag.
module updown_counter #(
  parameter int WIDTH  = 4,
  parameter int MAXVAL = 2**WIDTH - 1,
  parameter bit SAT    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAXVAL);

  logic [WIDTH-1:0] q_q, q_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the if/else chain can leave one unassigned and infer a latch.
    q_d   = q_q;
    tc_d  = 1'b0;
    ovf_d = ovf_q;

    if (clr) begin
      q_d   = '0;
      ovf_d = 1'b0;
    end else if (load) begin
      // Clamp out-of-range load values so q can never exceed MAXVAL.
      q_d = (din > MAX_Q) ? MAX_Q : din;
    end else if (en) begin
      if (up) begin
        if (q_q == MAX_Q) begin
          q_d   = SAT ? MAX_Q : '0;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q + WIDTH'(1);
        end
      end else begin
        if (q_q == '0) begin
          q_d   = SAT ? '0 : MAX_Q;
          tc_d  = 1'b1;
          ovf_d = 1'b1;
        end else begin
          q_d = q_q - WIDTH'(1);
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update
  // together from values sampled before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q   <= '0;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q   = q_q;
  assign tc  = tc_q;
  assign ovf = ovf_q;

endmodule

// File: tb/tb_updown_counter.sv
// Scoreboard bench for updown_counter: three instances (wrap/15, wrap/9,
// saturate/9) driven by directed vectors; a monitor pops expectations per cycle.
module tb_updown_counter;

  typedef struct packed {
    logic [3:0] q;
    logic       tc;
    logic       ovf;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       en_i   [3];
  logic       up_i   [3];
  logic       clr_i  [3];
  logic       load_i [3];
  logic [3:0] din_i  [3];
  logic [3:0] q_o    [3];
  logic       tc_o   [3];
  logic       ovf_o  [3];

  exp_t exp_a[$];
  exp_t exp_b[$];
  exp_t exp_c[$];

  int total = 0;
  int bad   = 0;

  updown_counter #(.WIDTH(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en_i[0]), .up(up_i[0]), .clr(clr_i[0]),
    .load(load_i[0]), .din(din_i[0]), .q(q_o[0]), .tc(tc_o[0]), .ovf(ovf_o[0])
  );

  updown_counter #(.WIDTH(4), .MAXVAL(9), .SAT(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en_i[1]), .up(up_i[1]), .clr(clr_i[1]),
    .load(load_i[1]), .din(din_i[1]), .q(q_o[1]), .tc(tc_o[1]), .ovf(ovf_o[1])
  );

  updown_counter #(.WIDTH(4), .MAXVAL(9), .SAT(1'b1)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en_i[2]), .up(up_i[2]), .clr(clr_i[2]),
    .load(load_i[2]), .din(din_i[2]), .q(q_o[2]), .tc(tc_o[2]), .ovf(ovf_o[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int n, input exp_t act, input exp_t xp);
    total++;
    if (act !== xp) begin
      bad++;
      $display("FAIL %s item %0d: got q=%0d tc=%0b ovf=%0b, want q=%0d tc=%0b ovf=%0b",
               name, n, act.q, act.tc, act.ovf, xp.q, xp.tc, xp.ovf);
    end
  endtask

  // Monitor: outputs are sampled on the falling edge, away from the active edge.
  initial begin : monitor
    int   na = 0;
    int   nb = 0;
    int   nc = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        check("dut_a", na, {q_o[0], tc_o[0], ovf_o[0]}, e);
        na++;
      end
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        check("dut_b", nb, {q_o[1], tc_o[1], ovf_o[1]}, e);
        nb++;
      end
      if (exp_c.size() > 0) begin
        e = exp_c.pop_front();
        check("dut_c", nc, {q_o[2], tc_o[2], ovf_o[2]}, e);
        nc++;
      end
    end
  end

  task automatic idle_all();
    for (int k = 0; k < 3; k++) begin
      en_i[k]   = 1'b0;
      up_i[k]   = 1'b0;
      clr_i[k]  = 1'b0;
      load_i[k] = 1'b0;
      din_i[k]  = 4'd0;
    end
  endtask

  // Drive one cycle of inputs on instance s and queue the response expected
  // after the next rising edge.
  task automatic step(input int s, input logic e, input logic u, input logic c,
                      input logic l, input logic [3:0] d,
                      input logic [3:0] xq, input logic xtc, input logic xovf);
    @(negedge clk);
    #1;
    idle_all();
    en_i[s]   = e;
    up_i[s]   = u;
    clr_i[s]  = c;
    load_i[s] = l;
    din_i[s]  = d;
    case (s)
      0:       exp_a.push_back({xq, xtc, xovf});
      1:       exp_b.push_back({xq, xtc, xovf});
      default: exp_c.push_back({xq, xtc, xovf});
    endcase
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    idle_all();

    // Held in reset: active inputs must be ignored.
    step(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd5, 4'd0, 1'b0, 1'b0);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b0, 1'b1, 4'd7, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    #1;
    idle_all();
    rst_n = 1'b1;

    // Default counter counts up through 15 and wraps to 0 on the 16th step.
    for (int i = 1; i <= 17; i++)
      step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'(i % 16), (i == 16), (i >= 16));
    step(0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1);

    // Direction toggling every enabled cycle from q=2.
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 4'd2, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b1);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b1);

    // Priority: clear beats load and enable; load beats enable.
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd5, 4'd5, 1'b0, 1'b1);
    step(0, 1'b1, 1'b1, 1'b1, 1'b1, 4'd9, 4'd0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b1, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0);

    // Count down through zero: modulo wrap to 15.
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);
    step(0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd15, 1'b1, 1'b1);
    step(0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, 4'd7, 1'b0, 1'b1);

    // Asynchronous reset between edges at q=7, ovf=1.
    @(negedge clk);
    #1;
    idle_all();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_a.push_back({4'd0, 1'b0, 1'b0});
    @(negedge clk);
    #1;
    rst_n     = 1'b1;
    en_i[0]   = 1'b1;
    up_i[0]   = 1'b1;
    exp_a.push_back({4'd1, 1'b0, 1'b0});
    step(0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0);

    // MAXVAL=9 wrap: down from 0 goes to 9, then 8, 7.
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd8, 1'b0, 1'b1);
    step(1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd7, 1'b0, 1'b1);
    step(1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd15, 4'd9, 1'b0, 1'b1);
    step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    step(1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1);

    // MAXVAL=9 saturate: clamped load, repeated tc at the upper bound.
    step(2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd12, 4'd9, 1'b0, 1'b0);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b1, 1'b1);
    step(2, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, 4'd9, 1'b0, 1'b1);
    step(2, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1);
    step(2, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 1'b1);
    step(2, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b1);
    step(2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 1'b0);

    @(negedge clk);
    #1;
    idle_all();
    repeat (3) @(negedge clk);
    #1;
    total++;
    if ((exp_a.size() + exp_b.size() + exp_c.size()) != 0) begin
      bad++;
      $display("FAIL drain: got %0d unchecked expectations, want 0",
               exp_a.size() + exp_b.size() + exp_c.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
